// File: rtl/ex_mem_pkg.sv
// Shared widths, stall bit indices and the execute->memory write-back payload for ex_mem.
package ex_mem_pkg;

  localparam int unsigned REGS_DATA_BUS        = 32;
  localparam int unsigned REGS_ADDR_BUS        = 5;
  localparam int unsigned DOUBLE_REGS_DATA_BUS = 64;
  localparam int unsigned CYCLE_BUS            = 2;
  localparam int unsigned STALL_BUS            = 6;

  localparam int unsigned STALL_EX  = 3;
  localparam int unsigned STALL_MEM = 4;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [REGS_DATA_BUS-1:0] ZERO_WORD = '0;

  // GPR and HI/LO write-back request carried from execute into memory
  typedef struct packed {
    logic [REGS_ADDR_BUS-1:0] write_addr;
    logic                     write_enable;
    logic [REGS_DATA_BUS-1:0] write_data;
    logic                     write_hilo_enable;
    logic [REGS_DATA_BUS-1:0] write_hi_data;
    logic [REGS_DATA_BUS-1:0] write_lo_data;
  } wb_req_t;

endpackage

// File: rtl/ex_mem_hilo_acc_reg.sv
// Partial-product and step register for two-cycle MADD/MSUB; clear has priority over capture.
module hilo_acc_reg
  import ex_mem_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            capture,
  input  logic                            clear,
  input  logic [DOUBLE_REGS_DATA_BUS-1:0] in_result,
  input  logic [CYCLE_BUS-1:0]            in_cycle,
  output logic [DOUBLE_REGS_DATA_BUS-1:0] result,
  output logic [CYCLE_BUS-1:0]            cycle
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result <= {ZERO_WORD, ZERO_WORD};
      cycle  <= '0;
    end else if (clear) begin
      result <= {ZERO_WORD, ZERO_WORD};
      cycle  <= '0;
    end else if (capture) begin
      result <= in_result;
      cycle  <= in_cycle;
    end
  end

endmodule

// File: rtl/ex_mem.sv
// Execute->memory pipeline register with stall/bubble/flush handling.
// Define MULTICYCLE_ACC_EN to build the MADD/MSUB partial-result accumulator.
module ex_mem
  import ex_mem_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic [STALL_BUS-1:0]            stall,
  input  logic                            flush,
  input  logic [REGS_ADDR_BUS-1:0]        ex_write_addr,
  input  logic                            ex_write_enable,
  input  logic [REGS_DATA_BUS-1:0]        ex_write_data,
  input  logic                            ex_write_hilo_enable,
  input  logic [REGS_DATA_BUS-1:0]        ex_write_hi_data,
  input  logic [REGS_DATA_BUS-1:0]        ex_write_lo_data,
  input  logic [DOUBLE_REGS_DATA_BUS-1:0] ex_current_result,
  input  logic [CYCLE_BUS-1:0]            ex_current_cycle,
  output logic [REGS_ADDR_BUS-1:0]        mem_write_addr,
  output logic                            mem_write_enable,
  output logic [REGS_DATA_BUS-1:0]        mem_write_data,
  output logic                            mem_write_hilo_enable,
  output logic [REGS_DATA_BUS-1:0]        mem_write_hi_data,
  output logic [REGS_DATA_BUS-1:0]        mem_write_lo_data,
  output logic [DOUBLE_REGS_DATA_BUS-1:0] last_result,
  output logic [CYCLE_BUS-1:0]            last_cycle
);

  wb_req_t ex_req_c;
  wb_req_t req;
  logic    bubble_c;
  logic    hold_c;

  // Execute held while memory runs -> bubble; memory held (legal or not) -> freeze
  assign bubble_c = (stall[STALL_EX] == ENABLE) && (stall[STALL_MEM] == DISABLE);
  assign hold_c   = (stall[STALL_MEM] == ENABLE);

  assign ex_req_c = '{write_addr:        ex_write_addr,
                      write_enable:      ex_write_enable,
                      write_data:        ex_write_data,
                      write_hilo_enable: ex_write_hilo_enable,
                      write_hi_data:     ex_write_hi_data,
                      write_lo_data:     ex_write_lo_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req <= '0;
    end else if (flush || bubble_c) begin
      req <= '0;
    end else if (!hold_c) begin
      req <= ex_req_c;
    end
  end

  assign mem_write_addr        = req.write_addr;
  assign mem_write_enable      = req.write_enable;
  assign mem_write_data        = req.write_data;
  assign mem_write_hilo_enable = req.write_hilo_enable;
  assign mem_write_hi_data     = req.write_hi_data;
  assign mem_write_lo_data     = req.write_lo_data;

`ifdef MULTICYCLE_ACC_EN
  logic acc_clear_c;
  logic unused_stall_c;

  // Advancing finishes any multi-cycle op, so the next one starts from step 0
  assign acc_clear_c    = flush || (!stall[STALL_EX] && !stall[STALL_MEM]);
  assign unused_stall_c = ^{stall[STALL_BUS-1], stall[STALL_EX-1:0]};

  hilo_acc_reg u_hilo_acc_reg (
    .clock     (clock),
    .reset     (reset),
    .capture   (bubble_c),
    .clear     (acc_clear_c),
    .in_result (ex_current_result),
    .in_cycle  (ex_current_cycle),
    .result    (last_result),
    .cycle     (last_cycle)
  );
`else
  logic unused_acc_c;

  assign last_result  = {ZERO_WORD, ZERO_WORD};
  assign last_cycle   = '0;
  assign unused_acc_c = ^{ex_current_result, ex_current_cycle,
                          stall[STALL_BUS-1], stall[STALL_EX-1:0]};
`endif

endmodule

// File: tb/tb_ex_mem.sv
// Scoreboard bench for ex_mem: a reference model predicts each edge, results are queued and popped after the edge.
module tb_ex_mem;

`ifdef MULTICYCLE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  wa;
    logic        we;
    logic [31:0] wd;
    logic        he;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] lr;
    logic [1:0]  lc;
  } obs_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [4:0]  ex_write_addr = '0;
  logic        ex_write_enable = 1'b0;
  logic [31:0] ex_write_data = '0;
  logic        ex_write_hilo_enable = 1'b0;
  logic [31:0] ex_write_hi_data = '0;
  logic [31:0] ex_write_lo_data = '0;
  logic [63:0] ex_current_result = '0;
  logic [1:0]  ex_current_cycle = '0;
  logic [4:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_write_hilo_enable;
  logic [31:0] mem_write_hi_data;
  logic [31:0] mem_write_lo_data;
  logic [63:0] last_result;
  logic [1:0]  last_cycle;

  ex_mem dut (
    .clock                 (clock),
    .reset                 (reset),
    .stall                 (stall),
    .flush                 (flush),
    .ex_write_addr         (ex_write_addr),
    .ex_write_enable       (ex_write_enable),
    .ex_write_data         (ex_write_data),
    .ex_write_hilo_enable  (ex_write_hilo_enable),
    .ex_write_hi_data      (ex_write_hi_data),
    .ex_write_lo_data      (ex_write_lo_data),
    .ex_current_result     (ex_current_result),
    .ex_current_cycle      (ex_current_cycle),
    .mem_write_addr        (mem_write_addr),
    .mem_write_enable      (mem_write_enable),
    .mem_write_data        (mem_write_data),
    .mem_write_hilo_enable (mem_write_hilo_enable),
    .mem_write_hi_data     (mem_write_hi_data),
    .mem_write_lo_data     (mem_write_lo_data),
    .last_result           (last_result),
    .last_cycle            (last_cycle)
  );

  always #5 clock = ~clock;

  int   total = 0;
  int   bad = 0;
  int   illegal_cnt = 0;
  obs_t model = '0;
  obs_t sb_q[$];

  // Controller must never hold memory while execute advances
  always @(posedge clock) begin
    if (reset && !stall[3] && stall[4]) begin
      illegal_cnt++;
      $display("note: illegal stall vector %b at %0t", stall, $time);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input obs_t e);
    check({tag, ".wa"}, 64'(mem_write_addr), 64'(e.wa));
    check({tag, ".we"}, 64'(mem_write_enable), 64'(e.we));
    check({tag, ".wd"}, 64'(mem_write_data), 64'(e.wd));
    check({tag, ".he"}, 64'(mem_write_hilo_enable), 64'(e.he));
    check({tag, ".hi"}, 64'(mem_write_hi_data), 64'(e.hi));
    check({tag, ".lo"}, 64'(mem_write_lo_data), 64'(e.lo));
    check({tag, ".lr"}, last_result, e.lr);
    check({tag, ".lc"}, 64'(last_cycle), 64'(e.lc));
  endtask

  // Drive one cycle of stimulus, predict the post-edge state, compare after the edge
  task automatic step(input string tag, input logic fl, input logic [5:0] st,
                      input logic [4:0] wa, input logic we, input logic [31:0] wd,
                      input logic he, input logic [31:0] hi, input logic [31:0] lo,
                      input logic [63:0] cr, input logic [1:0] cc);
    obs_t nx;
    @(negedge clock);
    flush = fl; stall = st;
    ex_write_addr = wa; ex_write_enable = we; ex_write_data = wd;
    ex_write_hilo_enable = he; ex_write_hi_data = hi; ex_write_lo_data = lo;
    ex_current_result = cr; ex_current_cycle = cc;
    nx = model;
    if (fl) begin
      nx = '0;
    end else if (st[3] && !st[4]) begin
      nx = '0;
      nx.lr = ACC_EN ? cr : 64'd0;
      nx.lc = ACC_EN ? cc : 2'd0;
    end else if (!st[4]) begin
      nx = '{wa: wa, we: we, wd: wd, he: he, hi: hi, lo: lo, lr: 64'd0, lc: 2'd0};
    end
    model = nx;
    sb_q.push_back(nx);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 64'd1, 64'd0);
    end else begin
      check_all(tag, sb_q.pop_front());
    end
  endtask

  task automatic rand_step(input string tag, input logic fl, input logic [5:0] st);
    step(tag, fl, st, 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
         $urandom, {$urandom, $urandom}, 2'($urandom));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [5:0] pick;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset", obs_t'(0));
    @(negedge clock);
    reset = 1'b1;

    step("advance", 1'b0, 6'b000000, 5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h0, 2'd0);
    step("bubble", 1'b0, 6'b001111, 5'd7, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'h2,
         64'h0000_0001_0000_0002, 2'd1);

    step("pre_hold", 1'b0, 6'b000000, 5'd9, 1'b1, 32'hCAFE_0009, 1'b1, 32'h99, 32'h77, 64'h5, 2'd2);
    for (int i = 0; i < 3; i++) rand_step("hold", 1'b0, 6'b011111);
    step("bubble_b4_hold", 1'b0, 6'b001111, 5'd1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 64'hABCD_0000_1234, 2'd1);
    for (int i = 0; i < 3; i++) rand_step("hold_acc", 1'b0, 6'b011111);

    // Two-cycle MADD: bubble at step 1, then final HI/LO advances and the step clears
    step("madd_s1", 1'b0, 6'b001111, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 64'h0000_0003_0000_0004, 2'd1);
    step("madd_s2", 1'b0, 6'b000000, 5'd0, 1'b0, 32'h0, 1'b1, 32'hA, 32'hB, 64'h0, 2'd0);

    step("pre_flush", 1'b0, 6'b001111, 5'd3, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 64'h55, 2'd1);
    step("flush_bubble", 1'b1, 6'b001111, 5'd4, 1'b1, 32'h4, 1'b1, 32'h4, 32'h4, 64'h66, 2'd1);
    step("flush_hold", 1'b1, 6'b011111, 5'd4, 1'b1, 32'h4, 1'b1, 32'h4, 32'h4, 64'h66, 2'd1);

    step("pre_illegal", 1'b0, 6'b000000, 5'd12, 1'b1, 32'h0BAD_F00D, 1'b1, 32'h12, 32'h34, 64'h0, 2'd0);
    rand_step("illegal_hold", 1'b0, 6'b010000);
    check("illegal_seen", 64'(illegal_cnt), 64'd1);

    for (int i = 0; i < 60; i++) begin
      pick = ($urandom_range(0, 2) == 0) ? 6'b000000 :
             ($urandom_range(0, 1) == 0) ? 6'b001111 : 6'b011111;
      if (pick == 6'b000000 && $urandom_range(0, 1) == 1) pick = 6'b000011;
      rand_step("random", ($urandom_range(0, 7) == 0), pick);
    end

    // Asynchronous reset between edges must clear outputs without a clock edge
    step("pre_areset", 1'b0, 6'b001111, 5'd8, 1'b1, 32'h8, 1'b1, 32'h8, 32'h8, 64'h1234, 2'd1);
    step("pre_areset2", 1'b0, 6'b000000, 5'd8, 1'b1, 32'h8, 1'b1, 32'h8, 32'h8, 64'h0, 2'd0);
    #1;
    reset = 1'b0;
    #1;
    check_all("areset", obs_t'(0));
    model = '0;
    @(negedge clock);
    reset = 1'b1;
    step("post_areset", 1'b0, 6'b000000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF,
         32'hFFFF_FFFF, 64'h0, 2'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
